// File: rtl/counter_2421_seq_ctrl.sv
// Run/stop/clear sequencer for a 2421 (Aiken) decade-counter cascade; define SEQ_ILLEGAL_CODE_CHECK_EN to add the ERR state.
// digit_x is combinational off registered state; digit_clr/wrap registered; no backpressure, commands sampled every clock.
module counter_2421_seq_ctrl #(
    parameter int NUM_DIGITS = 3,
    parameter int TICK_DIV   = 4,
    parameter int CNT_W      = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    clear,
    input  logic [4*NUM_DIGITS-1:0] target,
    input  logic [4*NUM_DIGITS-1:0] digit_z,
    output logic [NUM_DIGITS-1:0]   digit_x,
    output logic                    digit_clr,
    output logic                    busy,
    output logic                    done,
    output logic                    wrap,
    output logic [2:0]              state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
`ifdef SEQ_ILLEGAL_CODE_CHECK_EN
        ,
        S_ERR   = 3'd5
`endif
    } state_t;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    state_t            state_r;
    state_t            state_nxt;
    logic [CNT_W-1:0]  presc_r;
    logic [CNT_W-1:0]  presc_nxt;
    logic              tick;
    logic              match;
    logic              all_nines;
    logic [NUM_DIGITS-1:0] nibble_max;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_nib
        assign nibble_max[i] = (digit_z[4*i +: 4] == 4'b1111);
    end

`ifdef SEQ_ILLEGAL_CODE_CHECK_EN
    logic [NUM_DIGITS-1:0] nibble_bad;
    logic                  illegal;

    // 0101..1010 are the six codes 2421 never produces
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_bad
        assign nibble_bad[i] = (digit_z[4*i +: 4] >= 4'd5) && (digit_z[4*i +: 4] <= 4'd10);
    end
    assign illegal = |nibble_bad;
`endif

    assign tick      = (presc_r == TICK_LAST);
    assign match     = (digit_z == target);
    assign all_nines = &nibble_max;

    // A digit ripples when every lower digit sits at 9 (1111) on a live tick.
    always_comb begin
        digit_x = '0;
        if (state_r == S_RUN) begin
            digit_x[0] = tick & ~match;
            for (int i = 1; i < NUM_DIGITS; i++) begin
                digit_x[i] = digit_x[i-1] & nibble_max[i-1];
            end
        end
    end

    always_comb begin
        state_nxt = state_r;
        case (state_r)
            S_IDLE: begin
                if (clear) begin
                    state_nxt = S_CLEAR;
                end else if (start && !stop) begin
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_nxt = start ? S_RUN : S_IDLE;
            end
            S_RUN: begin
`ifdef SEQ_ILLEGAL_CODE_CHECK_EN
                if (illegal) begin
                    state_nxt = S_ERR;
                end else
`endif
                if (match) begin
                    state_nxt = S_DONE;
                end else if (stop) begin
                    state_nxt = S_PAUSE;
                end else if (clear) begin
                    state_nxt = S_CLEAR;
                end
            end
            S_PAUSE: begin
`ifdef SEQ_ILLEGAL_CODE_CHECK_EN
                if (illegal) begin
                    state_nxt = S_ERR;
                end else
`endif
                if (clear) begin
                    state_nxt = S_CLEAR;
                end else if (start && !stop) begin
                    state_nxt = S_RUN;
                end
            end
            S_DONE: begin
                if (clear) begin
                    state_nxt = S_CLEAR;
                end
            end
`ifdef SEQ_ILLEGAL_CODE_CHECK_EN
            S_ERR: begin
                if (clear) begin
                    state_nxt = S_CLEAR;
                end
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    // Prescaler advances on every RUN cycle, including the one that leaves RUN,
    // so a resumed run picks up exactly where the paused phase left off.
    always_comb begin
        presc_nxt = presc_r;
        if (state_nxt == S_CLEAR) begin
            presc_nxt = '0;
        end else if (state_r == S_RUN) begin
            presc_nxt = tick ? '0 : presc_r + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= S_IDLE;
            presc_r   <= '0;
            digit_clr <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            state_r   <= state_nxt;
            presc_r   <= presc_nxt;
            digit_clr <= (state_nxt == S_CLEAR);
            if (state_nxt == S_CLEAR) begin
                wrap <= 1'b0;
            end else if (digit_x[0] && all_nines) begin
                wrap <= 1'b1;
            end
        end
    end

    assign busy  = (state_r == S_RUN);
    assign done  = (state_r == S_DONE);
    assign state = state_r;

endmodule

// File: tb/tb_counter_2421_seq_ctrl.sv
// Directed bench for counter_2421_seq_ctrl with a behavioural 3-digit 2421 counter bank in the loop.
module tb_counter_2421_seq_ctrl;

    localparam int ND = 3;

    logic          clk;
    logic          rst;
    logic          start;
    logic          stop;
    logic          clear;
    logic [4*ND-1:0] target;
    logic [4*ND-1:0] digit_z;
    logic [ND-1:0] digit_x;
    logic          digit_clr;
    logic          busy;
    logic          done;
    logic          wrap;
    logic [2:0]    state;

    logic [4*ND-1:0] bank;
    logic          load_en;
    logic [4*ND-1:0] load_val;
    logic          force_en;
    logic [4*ND-1:0] force_val;

    int checks = 0;
    int errors = 0;
    logic [4*ND-1:0] exp_q[$];
    logic [4*ND-1:0] prev_z;

    counter_2421_seq_ctrl #(.NUM_DIGITS(ND), .TICK_DIV(4), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
        .target    (target),
        .digit_z   (digit_z),
        .digit_x   (digit_x),
        .digit_clr (digit_clr),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] inc2421(input logic [3:0] c);
        case (c)
            4'h0: inc2421 = 4'h1;
            4'h1: inc2421 = 4'h2;
            4'h2: inc2421 = 4'h3;
            4'h3: inc2421 = 4'h4;
            4'h4: inc2421 = 4'hB;
            4'hB: inc2421 = 4'hC;
            4'hC: inc2421 = 4'hD;
            4'hD: inc2421 = 4'hE;
            4'hE: inc2421 = 4'hF;
            4'hF: inc2421 = 4'h0;
            default: inc2421 = c;
        endcase
    endfunction

    // Counter bank: clear beats count; load is a bench-only preset.
    always @(posedge clk) begin
        if (load_en) begin
            bank <= load_val;
        end else if (digit_clr) begin
            bank <= '0;
        end else begin
            for (int i = 0; i < ND; i++) begin
                if (digit_x[i]) bank[4*i +: 4] <= inc2421(bank[4*i +: 4]);
            end
        end
    end

    assign digit_z = force_en ? force_val : bank;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_pop(input string tag);
        logic [4*ND-1:0] e;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = 'x;
        chk(tag, 16'(digit_z), 16'(e));
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
        target = '0; load_en = 1'b1; load_val = 12'h123;
        force_en = 1'b0; force_val = '0;
        cyc(); cyc();
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_wrap", 16'(wrap), 16'd0);
        chk("rst_clr", 16'(digit_clr), 16'd0);
        chk("rst_x", 16'(digit_x), 16'd0);
        load_en = 1'b0;
        rst = 1'b1;

        // Count to 3 with a tick every 4th clock
        target = 12'h003;
        start = 1'b1;
        cyc();
        chk("t1_clear_state", 16'(state), 16'd1);
        chk("t1_clr_pulse", 16'(digit_clr), 16'd1);
        cyc();
        chk("t1_run_state", 16'(state), 16'd2);
        chk("t1_clr_low", 16'(digit_clr), 16'd0);
        chk("t1_bank_cleared", 16'(digit_z), 16'h000);
        start = 1'b0;
        exp_q.push_back(12'h001);
        exp_q.push_back(12'h002);
        exp_q.push_back(12'h003);
        prev_z = digit_z;
        for (int k = 0; k < 16; k++) begin
            chk("t1_x", 16'(digit_x), ((k % 4 == 3) && (k < 12)) ? 16'd1 : 16'd0);
            chk("t1_done", 16'(done), (k >= 13) ? 16'd1 : 16'd0);
            cyc();
            if (digit_z != prev_z) begin
                sb_pop("t1_count");
                prev_z = digit_z;
            end
        end
        chk("t1_sb_drained", 16'(exp_q.size()), 16'd0);
        start = 1'b1;
        cyc();
        chk("t1_done_holds", 16'(state), 16'd4);
        chk("t1_done_x", 16'(digit_x), 16'd0);
        start = 1'b0;

        // Carry ripple 099 -> 100
        clear = 1'b1;
        cyc();
        chk("t2_clear_state", 16'(state), 16'd1);
        clear = 1'b0;
        cyc();
        chk("t2_idle", 16'(state), 16'd0);
        target = 12'h555;
        start = 1'b1;
        cyc(); cyc();
        start = 1'b0;
        load_en = 1'b1; load_val = 12'h0FF;
        cyc();
        load_en = 1'b0;
        cyc(); cyc();
        chk("t2_carry_x", 16'(digit_x), 16'h7);
        exp_q.push_back(12'h100);
        cyc();
        sb_pop("t2_099_to_100");
        chk("t2_wrap_low", 16'(wrap), 16'd0);

        // Wrap 999 -> 000, sticky until CLEAR
        load_en = 1'b1; load_val = 12'hFFF;
        cyc();
        load_en = 1'b0;
        cyc(); cyc();
        chk("t3_wrap_x", 16'(digit_x), 16'h7);
        chk("t3_wrap_before", 16'(wrap), 16'd0);
        exp_q.push_back(12'h000);
        cyc();
        sb_pop("t3_999_to_000");
        chk("t3_wrap_set", 16'(wrap), 16'd1);
        chk("t3_still_run", 16'(state), 16'd2);
        repeat (4) cyc();
        chk("t3_wrap_sticky", 16'(wrap), 16'd1);
        chk("t3_count_on", 16'(digit_z), 16'h001);
        clear = 1'b1;
        cyc();
        chk("t3_clear_state", 16'(state), 16'd1);
        chk("t3_wrap_cleared", 16'(wrap), 16'd0);
        clear = 1'b0;
        cyc();
        chk("t3_idle", 16'(state), 16'd0);

        // Pause at prescaler 2, resume ticks one clock after start
        start = 1'b1;
        cyc(); cyc();
        start = 1'b0;
        cyc(); cyc();
        stop = 1'b1;
        chk("t4_p2_x", 16'(digit_x), 16'd0);
        cyc();
        chk("t4_pause", 16'(state), 16'd3);
        chk("t4_pause_busy", 16'(busy), 16'd0);
        repeat (3) cyc();
        chk("t4_pause_hold", 16'(state), 16'd3);
        chk("t4_pause_x", 16'(digit_x), 16'd0);
        chk("t4_no_count", 16'(digit_z), 16'h000);
        stop = 1'b0;
        start = 1'b1;
        #1;
        chk("t4_resume_x_pre", 16'(digit_x), 16'd0);
        cyc();
        chk("t4_resume_run", 16'(state), 16'd2);
        chk("t4_first_tick", 16'(digit_x), 16'd1);
        start = 1'b0;
        exp_q.push_back(12'h001);
        cyc();
        sb_pop("t4_count");

        // Command priority inside RUN
        start = 1'b1; stop = 1'b1; clear = 1'b1;
        cyc();
        chk("t5_all_to_pause", 16'(state), 16'd3);
        chk("t5_no_clr", 16'(digit_clr), 16'd0);
        stop = 1'b0; clear = 1'b0;
        cyc();
        chk("t5_rerun", 16'(state), 16'd2);
        clear = 1'b1;
        cyc();
        chk("t5_clear_state", 16'(state), 16'd1);
        chk("t5_clr_high", 16'(digit_clr), 16'd1);
        clear = 1'b0;
        cyc();
        chk("t5_run_again", 16'(state), 16'd2);
        chk("t5_clr_low", 16'(digit_clr), 16'd0);
        chk("t5_bank_zero", 16'(digit_z), 16'h000);
        start = 1'b0;

        // Zero target finishes immediately
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        cyc();
        target = 12'h000;
        start = 1'b1;
        cyc(); cyc();
        start = 1'b0;
        chk("t6_run", 16'(state), 16'd2);
        chk("t6_x_suppressed", 16'(digit_x), 16'd0);
        cyc();
        chk("t6_done", 16'(done), 16'd1);
        chk("t6_zero_counts", 16'(digit_z), 16'h000);

        // Async reset in the middle of a tick
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        cyc();
        target = 12'h555;
        start = 1'b1;
        cyc(); cyc();
        start = 1'b0;
        repeat (3) cyc();
        chk("t7_tick_live", 16'(digit_x), 16'd1);
        rst = 1'b0;
        #1;
        chk("t7_x_dropped", 16'(digit_x), 16'd0);
        chk("t7_state_idle", 16'(state), 16'd0);
        chk("t7_busy_low", 16'(busy), 16'd0);
        cyc();
        rst = 1'b1;
        start = 1'b1;
        cyc();
        chk("t7_restart_clr", 16'(digit_clr), 16'd1);
        cyc();
        start = 1'b0;
        chk("t7_restart_run", 16'(state), 16'd2);

`ifdef SEQ_ILLEGAL_CODE_CHECK_EN
        force_en = 1'b1;
        force_val = 12'h006;
        cyc();
        chk("t8_err_state", 16'(state), 16'd5);
        chk("t8_err_x", 16'(digit_x), 16'd0);
        chk("t8_err_busy", 16'(busy), 16'd0);
        chk("t8_err_done", 16'(done), 16'd0);
        clear = 1'b1;
        force_en = 1'b0;
        cyc();
        chk("t8_err_clear", 16'(state), 16'd1);
        clear = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
